// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder
//   Monitors a multiplexed, active-low 7-segment bus and recovers the displayed hex word by
//   inverting the standard glyph table. Each digit is captured once its anode/segment pattern
//   has been stable for SETTLE_CYC synchronised samples. A frame is committed one cycle after
//   every digit has been captured at least once. Illegal glyphs decode to 0 and set err_mask.
//
// Parameters
//   NUM_DIGITS  number of multiplexed digits (1..8)
//   SETTLE_CYC  identical consecutive samples required before a capture (>= 1)
//   STALE_CYC   cycles without a committed frame before o_stale asserts
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_seg_n        segments, active-low, [6]=g .. [0]=a
//   i_an_n         anode enables, active-low, bit i = digit i
//   o_value        last complete frame, digit i at [4i+3:4i]
//   o_frame_valid  one-cycle pulse when o_value / o_err_mask update
//   o_err_mask     bit i set = digit i glyph illegal in last frame
//   o_stale        no frame for STALE_CYC cycles
//
// Build option
//   SEG_STALE_EN   when defined, a saturating frame-age counter drives o_stale;
//                  otherwise o_stale is tied low and STALE_CYC has no effect.

module seven_segment_scan_decoder #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned STALE_CYC  = 1_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [6:0]              i_seg_n,
  input  logic [NUM_DIGITS-1:0]   i_an_n,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic                    o_frame_valid,
  output logic [NUM_DIGITS-1:0]   o_err_mask,
  output logic                    o_stale
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYC);

  localparam logic [1:0] StBlank  = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StHeld   = 2'd2;

  // Inverse glyph table: returns {illegal, nibble}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg_n);
    logic [4:0] res;
    case (seg_n)
      7'b1000000: res = {1'b0, 4'h0};
      7'b1111001: res = {1'b0, 4'h1};
      7'b0100100: res = {1'b0, 4'h2};
      7'b0110000: res = {1'b0, 4'h3};
      7'b0011001: res = {1'b0, 4'h4};
      7'b0010010: res = {1'b0, 4'h5};
      7'b0000010: res = {1'b0, 4'h6};
      7'b1111000: res = {1'b0, 4'h7};
      7'b0000000: res = {1'b0, 4'h8};
      7'b0010000: res = {1'b0, 4'h9};
      7'b0001000: res = {1'b0, 4'hA};
      7'b0000011: res = {1'b0, 4'hB};
      7'b1000110: res = {1'b0, 4'hC};
      7'b0100001: res = {1'b0, 4'hD};
      7'b0000110: res = {1'b0, 4'hE};
      7'b0001110: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  // Two-flop synchroniser plus a copy of the previous synchronised sample for change detect.
  // Idle value is all-ones (display dark) so reset never looks like a lit digit.
  logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NUM_DIGITS-1:0] r_an_s1, r_an_s2, r_an_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
      r_an_s1    <= '1;
      r_an_s2    <= '1;
      r_an_prev  <= '1;
    end else begin
      r_seg_s1   <= i_seg_n;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_an_s1    <= i_an_n;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
    end
  end

  logic [NUM_DIGITS-1:0] w_sel;
  logic                  w_onehot;
  logic                  w_same;
  logic [4:0]            w_glyph;

  assign w_sel    = ~r_an_s2;
  assign w_onehot = ($countones(w_sel) == 1);
  assign w_same   = (r_seg_s2 == r_seg_prev) && (r_an_s2 == r_an_prev);
  assign w_glyph  = decode_glyph(r_seg_s2);

  // Settle FSM: r_cnt is the length of the current run of identical one-hot samples.
  logic [1:0]      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_capture;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_capture = 1'b0;
    if (!w_onehot) begin
      w_state_d = StBlank;
      w_cnt_d   = '0;
    end else if (r_state == StBlank || !w_same) begin
      // First sample of a new run.
      w_cnt_d = CntOne;
      if (CntOne == CntMax) begin
        w_capture = 1'b1;
        w_state_d = StHeld;
      end else begin
        w_state_d = StSettle;
      end
    end else if (r_state == StSettle) begin
      w_cnt_d = r_cnt + CntOne;
      if (w_cnt_d == CntMax) begin
        w_capture = 1'b1;
        w_state_d = StHeld;
      end
    end
    // StHeld with an unchanged bus: nothing to do until the bus moves.
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StBlank;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Frame assembly.
  logic [4*NUM_DIGITS-1:0] r_shadow, r_value;
  logic [NUM_DIGITS-1:0]   r_shadow_err, r_err_mask, r_mask, w_mask_base;
  logic                    r_frame_valid;
  logic                    w_commit;

  assign w_commit = &r_mask;
  // A capture landing on the commit edge starts the next frame.
  assign w_mask_base = w_commit ? '0 : r_mask;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow      <= '0;
      r_shadow_err  <= '0;
      r_mask        <= '0;
      r_value       <= '0;
      r_err_mask    <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      if (w_commit) begin
        r_value    <= r_shadow;
        r_err_mask <= r_shadow_err;
      end
      r_mask <= w_mask_base | (w_capture ? w_sel : '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_sel[i]) begin
          r_shadow[4*i +: 4] <= w_glyph[3:0];
          r_shadow_err[i]    <= w_glyph[4];
        end
      end
    end
  end

  assign o_value       = r_value;
  assign o_err_mask    = r_err_mask;
  assign o_frame_valid = r_frame_valid;

`ifdef SEG_STALE_EN
  localparam int unsigned StaleW = $clog2(STALE_CYC + 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(STALE_CYC);
  localparam logic [StaleW-1:0] StaleOne = StaleW'(1);

  // Frame age, cleared on commit, saturating at STALE_CYC.
  logic [StaleW-1:0] r_stale_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stale_cnt <= '0;
    end else if (w_commit) begin
      r_stale_cnt <= '0;
    end else if (r_stale_cnt != StaleMax) begin
      r_stale_cnt <= r_stale_cnt + StaleOne;
    end
  end

  assign o_stale = (r_stale_cnt == StaleMax);
`else
  // Monitor compiled out; STALE_CYC only kept for a common parameter list.
  assign o_stale = 1'b0 & (STALE_CYC != 0);
`endif

endmodule
